// File: rtl/config_subtractor_pipe_if.sv
// Streaming handshake bundle for config_subtractor_pipe: operand side and result side.
// The master drives operands and result backpressure; the slave is the subtractor.
interface config_subtractor_pipe_if #(
  parameter int unsigned P = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [P-1:0] a;
  logic [P-1:0] b;
  logic         halvedPrecision;
  logic         out_valid;
  logic         out_ready;
  logic [P+1:0] diff;
  logic         out_halved;

  modport master (
    output in_valid,
    output a,
    output b,
    output halvedPrecision,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  diff,
    input  out_halved
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  halvedPrecision,
    input  out_ready,
    output in_ready,
    output out_valid,
    output diff,
    output out_halved
  );
endinterface

// File: rtl/config_subtractor_pipe.sv
// Two-stage runtime-configurable subtractor: one P-bit difference or two packed P/2-bit
// differences, each widened by one bit so the exact signed result always fits.
module config_subtractor_pipe #(
  parameter int unsigned P = 8
) (
  input logic                    clk,
  input logic                    rst,
  config_subtractor_pipe_if.slave bus_io
);

  localparam int unsigned H = P / 2;

  // Stage 1 state: lower-half difference plus everything stage 2 still needs
  logic         s1_valid_q, s1_valid_d;
  logic [H-1:0] lo_q, lo_d;
  logic         lo_borrow_q, lo_borrow_d;
  logic         a_lo_sign_q, a_lo_sign_d;
  logic         b_lo_sign_q, b_lo_sign_d;
  logic [H-1:0] a_hi_q, a_hi_d;
  logic [H-1:0] b_hi_q, b_hi_d;
  logic         halved_q, halved_d;

  // Stage 2 / output state
  logic         out_valid_q, out_valid_d;
  logic [P+1:0] diff_q, diff_d;
  logic         out_halved_q, out_halved_d;

  logic         in_fire;
  logic         s2_load;
  logic [H:0]   lo_sum;
  logic         hi_cin;
  logic [H-1:0] hi;
  logic         hi_sign;
  logic         lo_sign;

  assign s2_load          = !out_valid_q || bus_io.out_ready;
  assign bus_io.in_ready  = !s1_valid_q || s2_load;
  assign in_fire          = bus_io.in_valid && bus_io.in_ready;

  assign bus_io.out_valid  = out_valid_q;
  assign bus_io.diff       = diff_q;
  assign bus_io.out_halved = out_halved_q;

  // Lower half as a + ~b + 1; a missing carry-out is a borrow.
  always_comb begin
    lo_sum = {1'b0, bus_io.a[H-1:0]} + {1'b0, ~bus_io.b[H-1:0]} + {{H{1'b0}}, 1'b1};
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    lo_d        = lo_q;
    lo_borrow_d = lo_borrow_q;
    a_lo_sign_d = a_lo_sign_q;
    b_lo_sign_d = b_lo_sign_q;
    a_hi_d      = a_hi_q;
    b_hi_d      = b_hi_q;
    halved_d    = halved_q;
    if (in_fire) begin
      s1_valid_d  = 1'b1;
      lo_d        = lo_sum[H-1:0];
      lo_borrow_d = ~lo_sum[H];
      a_lo_sign_d = bus_io.a[H-1];
      b_lo_sign_d = bus_io.b[H-1];
      a_hi_d      = bus_io.a[P-1:H];
      b_hi_d      = bus_io.b[P-1:H];
      halved_d    = bus_io.halvedPrecision;
    end else if (s2_load) begin
      s1_valid_d  = 1'b0;
    end
  end

  // Halved mode cuts the borrow chain so the two halves stay independent.
  always_comb begin
    hi_cin  = halved_q ? 1'b1 : ~lo_borrow_q;
    hi      = a_hi_q + ~b_hi_q + {{(H-1){1'b0}}, hi_cin};
    hi_sign = (a_hi_q[H-1] ^ b_hi_q[H-1]) ? a_hi_q[H-1] : hi[H-1];
    lo_sign = (a_lo_sign_q ^ b_lo_sign_q) ? a_lo_sign_q : lo_q[H-1];
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    diff_d       = diff_q;
    out_halved_d = out_halved_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_halved_d = halved_q;
        diff_d       = halved_q ? {hi_sign, hi, lo_sign, lo_q}
                                : {hi_sign, hi_sign, hi, lo_q};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      lo_q         <= '0;
      lo_borrow_q  <= 1'b0;
      a_lo_sign_q  <= 1'b0;
      b_lo_sign_q  <= 1'b0;
      a_hi_q       <= '0;
      b_hi_q       <= '0;
      halved_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      diff_q       <= '0;
      out_halved_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      lo_q         <= lo_d;
      lo_borrow_q  <= lo_borrow_d;
      a_lo_sign_q  <= a_lo_sign_d;
      b_lo_sign_q  <= b_lo_sign_d;
      a_hi_q       <= a_hi_d;
      b_hi_q       <= b_hi_d;
      halved_q     <= halved_d;
      out_valid_q  <= out_valid_d;
      diff_q       <= diff_d;
      out_halved_q <= out_halved_d;
    end
  end

endmodule
